store_buffer: RTL and testbench

In-order store buffer between the mem stage, the ROB commit port and data memory. The mem stage allocates speculative stores. The ROB later commits each store by index, or the front end discards all uncommitted stores on a flush. Committed stores drain in program order to data memory over a valid/ready request channel, and younger loads are checked against buffered stores.

---
 rtl/store_buffer_if.sv | 39 +++
 rtl/store_buffer.sv | 104 ++++++++++
 tb/tb_store_buffer.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// store_buffer_if: mem-stage allocate, ROB commit, memory drain and load-check signals of the store buffer
interface store_buffer_if #(
    parameter int IDX_W = 2
);
    logic             alloc_valid_i;
    logic [31:0]      alloc_addr_i;
    logic [31:0]      alloc_data_i;
    logic [1:0]       alloc_size_i;
    logic             alloc_ready_o;
    logic [IDX_W-1:0] alloc_idx_o;
    logic             commit_valid_i;
    logic [IDX_W-1:0] commit_idx_i;
    logic             discard_i;
    logic             mem_req_valid_o;
    logic [31:0]      mem_req_addr_o;
    logic [31:0]      mem_req_data_o;
    logic [3:0]       mem_req_be_o;
    logic             mem_req_ready_i;
    logic [31:0]      ld_addr_i;
    logic             ld_hit_o;
    logic [31:0]      ld_data_o;
    logic             full_o;
    logic             empty_o;
    logic             commit_err_o;

    modport master (
        output alloc_valid_i, alloc_addr_i, alloc_data_i, alloc_size_i, commit_valid_i, commit_idx_i,
               discard_i, mem_req_ready_i, ld_addr_i,
        input  alloc_ready_o, alloc_idx_o, mem_req_valid_o, mem_req_addr_o, mem_req_data_o, mem_req_be_o,
               ld_hit_o, ld_data_o, full_o, empty_o, commit_err_o
    );

    modport slave (
        input  alloc_valid_i, alloc_addr_i, alloc_data_i, alloc_size_i, commit_valid_i, commit_idx_i,
               discard_i, mem_req_ready_i, ld_addr_i,
        output alloc_ready_o, alloc_idx_o, mem_req_valid_o, mem_req_addr_o, mem_req_data_o, mem_req_be_o,
               ld_hit_o, ld_data_o, full_o, empty_o, commit_err_o
    );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: in-order commit/drain store buffer with load check; STORE_BUFFER_FWD_EN enables full-word load forwarding
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input logic         clk_i,
    input logic         rstn_i,
    store_buffer_if.slave sb
);
    logic [IDX_W:0]   head, cmt, tail, count, cmt_nxt;
    logic [IDX_W-1:0] hi, ti, li;
    logic [29:0]      addr_q [DEPTH];
    logic [3:0]       be_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [3:0]       be_new;
    logic [31:0]      data_new;
    logic [1:0]       lane;
    logic             alloc_fire, commit_ok, drain, err, any_hit;
    logic [1:0]       unused_ld;

    assign hi         = head[IDX_W-1:0];
    assign ti         = tail[IDX_W-1:0];
    assign count      = tail - head;
    assign lane       = sb.alloc_addr_i[1:0];
    assign unused_ld  = sb.ld_addr_i[1:0];
    assign sb.full_o  = (hi == ti) && (head[IDX_W] != tail[IDX_W]);
    assign sb.empty_o = head == tail;
    assign sb.alloc_ready_o = ~sb.full_o & ~sb.discard_i;
    assign sb.alloc_idx_o   = ti;
    assign sb.commit_err_o  = err;
    assign alloc_fire = sb.alloc_valid_i & sb.alloc_ready_o;
    assign commit_ok  = sb.commit_valid_i && sb.commit_idx_i == cmt[IDX_W-1:0] && cmt != tail;
    assign cmt_nxt    = cmt + (IDX_W+1)'(commit_ok);
    assign sb.mem_req_valid_o = head != cmt;
    assign sb.mem_req_addr_o  = {addr_q[hi], 2'b00};
    assign sb.mem_req_data_o  = data_q[hi];
    assign sb.mem_req_be_o    = be_q[hi];
    assign drain = sb.mem_req_valid_o & sb.mem_req_ready_i;

    // size 3 falls through to the word encoding
    always_comb begin
        be_new   = sb.alloc_size_i == 2'd0 ? 4'b0001 << lane :
                   sb.alloc_size_i == 2'd1 ? 4'b0011 << {lane[1], 1'b0} : 4'b1111;
        data_new = sb.alloc_size_i == 2'd0 ? {24'b0, sb.alloc_data_i[7:0]} << {lane, 3'b000} :
                   sb.alloc_size_i == 2'd1 ? {16'b0, sb.alloc_data_i[15:0]} << {lane[1], 4'b0000} :
                   sb.alloc_data_i;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            head <= '0;
            cmt  <= '0;
            tail <= '0;
            err  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                be_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head <= head + (IDX_W+1)'(drain);
            cmt  <= cmt_nxt;
            tail <= sb.discard_i ? cmt_nxt : tail + (IDX_W+1)'(alloc_fire);
            err  <= err | (sb.commit_valid_i & ~commit_ok) | (alloc_fire & (sb.alloc_size_i == 2'd3));
            if (alloc_fire) begin
                addr_q[ti] <= sb.alloc_addr_i[31:2];
                be_q[ti]   <= be_new;
                data_q[ti] <= data_new;
            end
        end
    end

`ifdef STORE_BUFFER_FWD_EN
    logic [IDX_W-1:0] y_idx;
    logic [3:0]       y_be;
`endif

    // walk from oldest to youngest so the last match wins
    always_comb begin
        any_hit = 1'b0;
        li      = '0;
`ifdef STORE_BUFFER_FWD_EN
        y_idx   = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            li = hi + IDX_W'(k);
            if ((IDX_W+1)'(k) < count && addr_q[li] == sb.ld_addr_i[31:2] && be_q[li] != 4'b0000) begin
                any_hit = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
                y_idx   = li;
`endif
            end
        end
    end

`ifdef STORE_BUFFER_FWD_EN
    assign y_be         = any_hit ? be_q[y_idx] : 4'b0000;
    assign sb.ld_hit_o  = &y_be;
    assign sb.ld_data_o = data_q[y_idx] & {{8{y_be[3]}}, {8{y_be[2]}}, {8{y_be[1]}}, {8{y_be[0]}}};
`else
    assign sb.ld_hit_o  = any_hit;
    assign sb.ld_data_o = '0;
`endif
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: scoreboard bench for store_buffer; expected drains are queued at commit and popped on handshake
module tb_store_buffer;
    localparam int IDX_W = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } req_t;

    logic clk_i = 1'b0;
    logic rstn_i = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_hs = 0;
    req_t q_pend[$];
    req_t q_exp[$];
    logic [IDX_W-1:0] m_cmt = '0;

    store_buffer_if #(.IDX_W(IDX_W)) sb();
    store_buffer #(.DEPTH(4)) dut (.clk_i(clk_i), .rstn_i(rstn_i), .sb(sb));

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    function automatic req_t model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        req_t r;
        r.addr = a & 32'hFFFF_FFFC;
        case (s)
            2'd0: begin r.be = 4'b0001 << a[1:0]; r.data = (d & 32'hFF) << (8 * a[1:0]); end
            2'd1: begin r.be = a[1] ? 4'b1100 : 4'b0011; r.data = a[1] ? (d << 16) : (d & 32'hFFFF); end
            default: begin r.be = 4'b1111; r.data = d; end
        endcase
        return r;
    endfunction

    always @(negedge clk_i) begin
        if (rstn_i && sb.mem_req_valid_o && sb.mem_req_ready_i) begin
            req_t e;
            n_hs++;
            n_checks++;
            if (q_exp.size() == 0) begin
                n_fail++;
                $display("FAIL drain_unexpected: got addr=%h data=%h be=%b, expected no request",
                         sb.mem_req_addr_o, sb.mem_req_data_o, sb.mem_req_be_o);
            end else begin
                e = q_exp.pop_front();
                if ({sb.mem_req_addr_o, sb.mem_req_data_o, sb.mem_req_be_o} !== e) begin
                    n_fail++;
                    $display("FAIL drain_req: got addr=%h data=%h be=%b, expected addr=%h data=%h be=%b",
                             sb.mem_req_addr_o, sb.mem_req_data_o, sb.mem_req_be_o, e.addr, e.data, e.be);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk_i); #1; end
    endtask

    task automatic do_reset();
        rstn_i = 1'b0;
        sb.alloc_valid_i = 0; sb.alloc_addr_i = 0; sb.alloc_data_i = 0; sb.alloc_size_i = 0;
        sb.commit_valid_i = 0; sb.commit_idx_i = 0; sb.discard_i = 0; sb.mem_req_ready_i = 0; sb.ld_addr_i = 0;
        q_pend.delete(); q_exp.delete(); m_cmt = '0;
        idle(2);
        rstn_i = 1'b1;
    endtask

    task automatic cyc(input bit av, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                       input bit cv, input logic [IDX_W-1:0] ci, input bit disc);
        bit acc, ok;
        sb.alloc_valid_i = av; sb.alloc_addr_i = a; sb.alloc_data_i = d; sb.alloc_size_i = s;
        sb.commit_valid_i = cv; sb.commit_idx_i = ci; sb.discard_i = disc;
        #1;
        acc = av && sb.alloc_ready_o;
        ok  = cv && q_pend.size() > 0 && ci == m_cmt;
        @(posedge clk_i);
        if (ok) begin q_exp.push_back(q_pend.pop_front()); m_cmt++; end
        if (acc) q_pend.push_back(model(a, d, s));
        if (disc) q_pend.delete();
        #1;
        sb.alloc_valid_i = 0; sb.commit_valid_i = 0; sb.discard_i = 0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50 && q_exp.size() != 0; i++) idle(1);
        idle(1);
        n_checks++;
        if (q_exp.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d requests outstanding, expected 0", q_exp.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks += 5;
        if (sb.empty_o !== 1'b1 || sb.full_o !== 1'b0) begin n_fail++; $display("FAIL reset_occ: got empty=%b full=%b, expected 1 0", sb.empty_o, sb.full_o); end
        if (sb.alloc_ready_o !== 1'b1 || sb.alloc_idx_o !== 2'd0) begin n_fail++; $display("FAIL reset_alloc: got ready=%b idx=%0d, expected 1 0", sb.alloc_ready_o, sb.alloc_idx_o); end
        if (sb.mem_req_valid_o !== 1'b0 || sb.mem_req_addr_o !== 32'h0 || sb.mem_req_data_o !== 32'h0 || sb.mem_req_be_o !== 4'h0) begin
            n_fail++; $display("FAIL reset_req: got v=%b a=%h d=%h be=%b, expected all 0", sb.mem_req_valid_o, sb.mem_req_addr_o, sb.mem_req_data_o, sb.mem_req_be_o);
        end
        if (sb.ld_hit_o !== 1'b0 || sb.ld_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_ld: got hit=%b data=%h, expected 0 0", sb.ld_hit_o, sb.ld_data_o); end
        if (sb.commit_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, expected 0", sb.commit_err_o); end
    endtask

    task automatic test_byte_store();
        do_reset();
        sb.mem_req_ready_i = 1;
        cyc(1, 32'h1003, 32'hAB, 2'd0, 0, 0, 0);
        n_checks++;
        if (sb.mem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL byte_precommit: got valid=%b, expected 0", sb.mem_req_valid_o); end
        cyc(0, 0, 0, 0, 1, 2'd0, 0);
        n_checks++;
        if ({sb.mem_req_valid_o, sb.mem_req_addr_o, sb.mem_req_be_o, sb.mem_req_data_o} !== {1'b1, 32'h1000, 4'b1000, 32'hAB00_0000}) begin
            n_fail++; $display("FAIL byte_req: got v=%b a=%h be=%b d=%h, expected 1 00001000 1000 ab000000",
                               sb.mem_req_valid_o, sb.mem_req_addr_o, sb.mem_req_be_o, sb.mem_req_data_o);
        end
        idle(1);
        n_checks++;
        if (sb.empty_o !== 1'b1 || sb.mem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL byte_empty: got empty=%b valid=%b, expected 1 0", sb.empty_o, sb.mem_req_valid_o); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (sb.alloc_idx_o !== 2'(i)) begin n_fail++; $display("FAIL fill_idx: got %0d, expected %0d", sb.alloc_idx_o, i); end
            cyc(1, 32'h6000 + 32'(i) * 4, 32'h1000 + 32'(i), 2'd2, 0, 0, 0);
        end
        n_checks++;
        if ({sb.full_o, sb.alloc_ready_o, sb.alloc_idx_o} !== {1'b1, 1'b0, 2'd0}) begin
            n_fail++; $display("FAIL fill_full: got full=%b ready=%b idx=%0d, expected 1 0 0", sb.full_o, sb.alloc_ready_o, sb.alloc_idx_o);
        end
        sb.mem_req_ready_i = 1;
        cyc(1, 32'h7000, 32'h5, 2'd2, 1, 2'd0, 0);
        n_checks++;
        if (sb.alloc_ready_o !== 1'b0 || sb.mem_req_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL fill_nobypass: got ready=%b valid=%b, expected 0 1", sb.alloc_ready_o, sb.mem_req_valid_o);
        end
        idle(1);
        n_checks++;
        if ({sb.full_o, sb.alloc_ready_o, sb.alloc_idx_o} !== {1'b0, 1'b1, 2'd0}) begin
            n_fail++; $display("FAIL fill_wrap: got full=%b ready=%b idx=%0d, expected 0 1 0", sb.full_o, sb.alloc_ready_o, sb.alloc_idx_o);
        end
        sb.mem_req_ready_i = 0;
        cyc(1, 32'h7000, 32'h5, 2'd2, 0, 0, 0);
        n_checks++;
        if (sb.alloc_idx_o !== 2'd1 || sb.full_o !== 1'b1) begin n_fail++; $display("FAIL fill_refill: got idx=%0d full=%b, expected 1 1", sb.alloc_idx_o, sb.full_o); end
    endtask

    task automatic test_discard();
        int hs0;
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, 32'h8000 + 32'(i) * 4, 32'hC0 + 32'(i), 2'd2, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 2'd0, 0);
        cyc(1, 32'h9000, 32'h1, 2'd2, 0, 0, 1);
        n_checks++;
        if (sb.alloc_idx_o !== 2'd1 || sb.empty_o !== 1'b0) begin n_fail++; $display("FAIL discard_tail: got idx=%0d empty=%b, expected 1 0", sb.alloc_idx_o, sb.empty_o); end
        hs0 = n_hs;
        sb.mem_req_ready_i = 1;
        wait_drain();
        idle(3);
        n_checks += 2;
        if (n_hs - hs0 !== 1) begin n_fail++; $display("FAIL discard_count: got %0d handshakes, expected 1", n_hs - hs0); end
        if (sb.empty_o !== 1'b1 || sb.mem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL discard_empty: got empty=%b valid=%b, expected 1 0", sb.empty_o, sb.mem_req_valid_o); end
        do_reset();
        cyc(1, 32'hA000, 32'h1, 2'd2, 0, 0, 0);
        cyc(1, 32'hA004, 32'h2, 2'd2, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 2'd0, 1);
        n_checks++;
        if ({sb.alloc_idx_o, sb.mem_req_valid_o, sb.commit_err_o} !== {2'd1, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL discard_commit: got idx=%0d valid=%b err=%b, expected 1 1 0", sb.alloc_idx_o, sb.mem_req_valid_o, sb.commit_err_o);
        end
        sb.mem_req_ready_i = 1;
        wait_drain();
    endtask

    task automatic test_ooo_commit();
        do_reset();
        cyc(1, 32'hB000, 32'h1, 2'd2, 0, 0, 0);
        cyc(1, 32'hB004, 32'h2, 2'd2, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 2'd1, 0);
        idle(1);
        n_checks++;
        if ({sb.commit_err_o, sb.mem_req_valid_o, sb.alloc_idx_o} !== {1'b1, 1'b0, 2'd2}) begin
            n_fail++; $display("FAIL ooo_commit: got err=%b valid=%b idx=%0d, expected 1 0 2", sb.commit_err_o, sb.mem_req_valid_o, sb.alloc_idx_o);
        end
        do_reset();
        cyc(1, 32'hB100, 32'h3, 2'd2, 1, 2'd0, 0);
        idle(1);
        n_checks++;
        if ({sb.commit_err_o, sb.mem_req_valid_o} !== {1'b1, 1'b0}) begin
            n_fail++; $display("FAIL same_cycle_commit: got err=%b valid=%b, expected 1 0", sb.commit_err_o, sb.mem_req_valid_o);
        end
    endtask

    task automatic test_backpressure();
        int hs0;
        do_reset();
        cyc(1, 32'h2000, 32'hDEAD_BEEF, 2'd2, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 2'd0, 0);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({sb.mem_req_valid_o, sb.mem_req_addr_o, sb.mem_req_data_o, sb.mem_req_be_o} !== {1'b1, 32'h2000, 32'hDEAD_BEEF, 4'hF}) begin
                n_fail++; $display("FAIL bp_hold: cycle %0d got v=%b a=%h d=%h be=%b, expected 1 00002000 deadbeef 1111",
                                   i, sb.mem_req_valid_o, sb.mem_req_addr_o, sb.mem_req_data_o, sb.mem_req_be_o);
            end
            cyc(1, 32'h2100 + 32'(i) * 4, 32'(i), 2'd2, 0, 0, 0);
        end
        q_pend.delete();
        hs0 = n_hs;
        sb.mem_req_ready_i = 1;
        wait_drain();
        idle(2);
        n_checks++;
        if (n_hs - hs0 !== 1) begin n_fail++; $display("FAIL bp_single: got %0d handshakes, expected 1", n_hs - hs0); end
    endtask

    task automatic test_illegal_size();
        do_reset();
        sb.mem_req_ready_i = 1;
        cyc(1, 32'h4002, 32'h1234_5678, 2'd3, 0, 0, 0);
        cyc(1, 32'h4006, 32'hA1B2_C3D4, 2'd1, 1, 2'd0, 0);
        cyc(1, 32'h4001, 32'h0000_00EE, 2'd0, 1, 2'd1, 0);
        cyc(0, 0, 0, 0, 1, 2'd2, 0);
        wait_drain();
        n_checks++;
        if (sb.commit_err_o !== 1'b1) begin n_fail++; $display("FAIL size3_err: got %b, expected 1", sb.commit_err_o); end
    endtask

    task automatic test_forward();
        do_reset();
        cyc(1, 32'h3000, 32'h1122_3344, 2'd2, 0, 0, 0);
        sb.ld_addr_i = 32'h3000; #1;
        n_checks++;
`ifdef STORE_BUFFER_FWD_EN
        if ({sb.ld_hit_o, sb.ld_data_o} !== {1'b1, 32'h1122_3344}) begin n_fail++; $display("FAIL fwd_word: got hit=%b data=%h, expected 1 11223344", sb.ld_hit_o, sb.ld_data_o); end
`else
        if ({sb.ld_hit_o, sb.ld_data_o} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL fwd_word: got hit=%b data=%h, expected 1 00000000", sb.ld_hit_o, sb.ld_data_o); end
`endif
        sb.ld_addr_i = 32'h3004; #1;
        n_checks++;
        if (sb.ld_hit_o !== 1'b0) begin n_fail++; $display("FAIL fwd_miss: got hit=%b, expected 0", sb.ld_hit_o); end
        cyc(1, 32'h5001, 32'h77, 2'd0, 0, 0, 0);
        sb.ld_addr_i = 32'h5000; #1;
        n_checks++;
`ifdef STORE_BUFFER_FWD_EN
        if (sb.ld_hit_o !== 1'b0) begin n_fail++; $display("FAIL fwd_partial: got hit=%b, expected 0", sb.ld_hit_o); end
`else
        if (sb.ld_hit_o !== 1'b1) begin n_fail++; $display("FAIL fwd_partial: got hit=%b, expected 1", sb.ld_hit_o); end
`endif
        cyc(1, 32'h3000, 32'h5566_7788, 2'd2, 0, 0, 0);
        sb.ld_addr_i = 32'h3000; #1;
        n_checks++;
`ifdef STORE_BUFFER_FWD_EN
        if ({sb.ld_hit_o, sb.ld_data_o} !== {1'b1, 32'h5566_7788}) begin n_fail++; $display("FAIL fwd_youngest: got hit=%b data=%h, expected 1 55667788", sb.ld_hit_o, sb.ld_data_o); end
`else
        if ({sb.ld_hit_o, sb.ld_data_o} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL fwd_youngest: got hit=%b data=%h, expected 1 00000000", sb.ld_hit_o, sb.ld_data_o); end
`endif
        sb.ld_addr_i = 0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        sb.mem_req_ready_i = 1;
        for (int i = 0; i < 16; i++) begin
            logic [31:0] a, d;
            a = 32'hC000 + 32'($urandom_range(0, 63));
            d = $urandom;
            cyc(1, a, d, 2'($urandom_range(0, 2)), q_pend.size() > 0, m_cmt, 0);
        end
        for (int i = 0; i < 8 && q_pend.size() > 0; i++) cyc(0, 0, 0, 0, 1, m_cmt, 0);
        wait_drain();
        n_checks++;
        if ({sb.empty_o, sb.commit_err_o} !== {1'b1, 1'b0}) begin n_fail++; $display("FAIL b2b_end: got empty=%b err=%b, expected 1 0", sb.empty_o, sb.commit_err_o); end
    endtask

    task automatic test_async_reset();
        do_reset();
        cyc(1, 32'hD000, 32'h99, 2'd2, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 2'd0, 0);
        n_checks++;
        if (sb.mem_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL arst_pre: got valid=%b, expected 1", sb.mem_req_valid_o); end
        #2 rstn_i = 1'b0;
        q_pend.delete(); q_exp.delete(); m_cmt = '0;
        #1;
        n_checks++;
        if ({sb.mem_req_valid_o, sb.empty_o} !== {1'b0, 1'b1}) begin n_fail++; $display("FAIL arst_drop: got valid=%b empty=%b, expected 0 1", sb.mem_req_valid_o, sb.empty_o); end
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
        idle(2);
    endtask

    initial begin
        test_reset();
        test_byte_store();
        test_fill();
        test_discard();
        test_ooo_commit();
        test_backpressure();
        test_illegal_size();
        test_forward();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
